sll_shifter_seq: RTL and testbench

- Multicycle logical-left shifter (SLL) for the pipeline CPU's execute-stage shift path.
- It is the opposite direction of the existing combinational right shifter.
- It applies one binary-weighted stage per clock (1, 2, 4, 8, then 16 bits), controlled by one shift-amount bit per stage.
- It uses a start/busy/done handshake, so the hazard unit can stall the pipeline while a shift is in flight; a flush input kills an in-flight shift.

---
 rtl/sll_shifter_seq.sv | 96 +++++++++
 tb/tb_sll_shifter_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sll_shifter_seq.sv
`timescale 1ns/1ps
// Multicycle logical-left shifter: one binary-weighted stage per clock, SHW shift cycles plus one DONE cycle.
// No backpressure: start is only accepted in IDLE, and flush aborts an in-flight shift without touching dataOut.
module sll_shifter_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataA,
  input  logic [SHW-1:0]   dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CW-1:0] LAST = CW'(SHW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_stage;
  logic [SHW-1:0]   shamt;
  logic [CW-1:0]    cnt;

  // Stage cnt shifts by 2**cnt when the matching shift-amount bit is set.
  always_comb begin
    acc_stage = acc;
    if (shamt[cnt]) begin
      acc_stage = acc << (32'd1 << cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      shamt   <= '0;
      cnt     <= '0;
      dataOut <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            acc   <= dataA;
            shamt <= dataB;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (!flush) begin
            acc <= acc_stage;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              dataOut <= acc_stage;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !flush) state_nxt = SHIFT;
      SHIFT: begin
        if (flush)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sll_shifter_seq.sv
`timescale 1ns/1ps
// Bench for sll_shifter_seq: directed vectors, handshake corner sequences and a random sweep against a << model.
module tb_sll_shifter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] dataA;
  logic [4:0]  dataB;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

  sll_shifter_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .dataA   (dataA),
    .dataB   (dataB),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge; counts edges (including that one) until done is seen.
  task automatic wait_done(output int edges, output int busy_cycles, output bit out_stable);
    logic [31:0] held;
    held        = dataOut;
    edges       = 1;
    busy_cycles = 0;
    out_stable  = 1'b1;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      if (dataOut !== held) out_stable = 1'b0;
      step();
      edges++;
    end
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [4:0] b,
                       input logic [31:0] exp);
    int  edges, bcnt;
    bit  stable;
    dataA = a;
    dataB = b;
    start = 1'b1;
    step();
    start = 1'b0;
    dataA = ~a;
    dataB = ~b;
    wait_done(edges, bcnt, stable);
    check({name, " latency"}, edges, 32'd6);
    check({name, " busy cycles"}, bcnt, 32'd5);
    check({name, " dataOut stable while busy"}, {31'd0, stable}, 32'd1);
    check({name, " result"}, dataOut, exp);
    check({name, " busy in done"}, {31'd0, busy}, 32'd0);
    step();
    check({name, " done one cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   edges, bcnt, npulse;
    bit   stable;
    logic [31:0] ra;
    logic [4:0]  rb;

    vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1] = '{32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[2] = '{32'hF000_000F, 5'd4,  32'h0000_00F0};
    vecs[3] = '{32'h0000_00FF, 5'd8,  32'h0000_FF00};
    vecs[4] = '{32'h8765_4321, 5'd17, 32'h8642_0000};
    vecs[5] = '{32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};

    rst = 1'b1; start = 1'b0; flush = 1'b0; dataA = '0; dataB = '0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset dataOut", dataOut, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Reset in the middle of a shift clears the result and the next op runs cleanly.
    dataA = 32'hFFFF_FFFF; dataB = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset dataOut", dataOut, 32'd0);
    step();
    do_op("after reset", 32'd1, 5'd1, 32'd2);

    // Start held high: requests during SHIFT/DONE are dropped, next op only from IDLE.
    dataA = 32'h0000_00FF; dataB = 5'd8; start = 1'b1;
    step();
    dataA = 32'h0000_0011; dataB = 5'd3;
    wait_done(edges, bcnt, stable);
    check("held start latency", edges, 32'd6);
    check("held start busy cycles", bcnt, 32'd5);
    check("held start result", dataOut, 32'h0000_FF00);
    step();
    check("held start idle after done", {31'd0, busy}, 32'd0);
    check("held start no second done", {31'd0, done}, 32'd0);
    step();
    start = 1'b0;
    check("held start second op accepted", {31'd0, busy}, 32'd1);
    wait_done(edges, bcnt, stable);
    check("second op latency", edges, 32'd6);
    check("second op result", dataOut, 32'h0000_0088);
    step();

    // Flush mid-shift keeps the previous result and produces no done pulse.
    do_op("preload", 32'h0000_ABCD, 5'd16, 32'hABCD_0000);
    dataA = 32'd3; dataB = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush dataOut", dataOut, 32'hABCD_0000);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) npulse++;
      step();
    end
    check("flush no later activity", npulse, 32'd0);
    check("flush dataOut held", dataOut, 32'hABCD_0000);

    // start together with flush in IDLE does nothing.
    dataA = 32'd5; dataB = 5'd1; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) npulse++;
      step();
    end
    check("start+flush ignored", npulse, 32'd0);
    check("start+flush dataOut", dataOut, 32'hABCD_0000);

    // Flush arriving in DONE does not cancel the already-committed result.
    dataA = 32'd7; dataB = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(edges, bcnt, stable);
    flush = 1'b1;
    check("flush in done pulse", {31'd0, done}, 32'd1);
    check("flush in done result", dataOut, 32'd56);
    step();
    flush = 1'b0;
    check("flush in done result kept", dataOut, 32'd56);
    step();

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = 5'($urandom_range(0, 31));
      do_op($sformatf("rand%0d", i), ra, rb, ra << rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
